ahb_sram_slave: RTL and testbench

AHB-Lite slave fronting an on-chip word-addressed SRAM. It is the responder for the core's AHB master port and sits behind the interconnect decoder as the instruction and data memory target. It implements the AHB address/data-phase pipeline, configurable wait states, byte/halfword/word writes and the two-cycle ERROR response.

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/ahb_sram_slave_if.sv | 36 +++
 rtl/ahb_sram_array.sv | 33 +++
 rtl/ahb_sram_slave.sv | 135 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings used by the SRAM slave and the core's
// master port.
// Contents:
//   HTRANS_*  transfer type codes
//   HSIZE_*   transfer size codes (byte/half/word only)
//   HRESP_*   response codes
//   ahb_state_e  slave data-phase FSM encoding
//   byte_en() lane enables for a transfer of a given size and offset
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } ahb_state_e;

    // Byte lanes touched by an aligned transfer. Misaligned or oversize
    // transfers never reach the write path, so only legal cases matter here.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << off;
            HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite signal bundle between a master (or decoder
// fabric) and one slave.
// Signals:
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK  address phase
//   HWDATA                                                       write data
//   HREADY                                                       bus-level ready
//   HRDATA, HREADYOUT, HRESP                                     slave response
interface ahb_sram_slave_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
        input  HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
        output HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: single-port DEPTH x 32 storage with per-byte write enables
// and an asynchronous read, shaped to map onto distributed RAM.
// Ports:
//   clk    write clock
//   we     byte-lane write enables (bit n writes wdata[8n+7:8n])
//   addr   word index shared by read and write
//   wdata  write data
//   rdata  combinational read of mem[addr]
module ahb_sram_array #(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // Contents are intentionally not reset.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder for an on-chip SRAM.
// Registers each accepted address phase, inserts WAIT_STATES low-ready
// cycles on OKAY transfers, commits writes with byte enables on the
// completing data-phase edge, and answers illegal transfers with the
// two-cycle ERROR response.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   ahb    AHB-Lite slave modport (address/data phase in, response out)
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_STATES     = 0
) (
    input  logic                clk,
    input  logic                reset,
    ahb_sram_slave_if.slave     ahb
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    ahb_state_e    state_q, state_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic [1:0]    off_q,   off_d;
    logic [2:0]    size_q,  size_d;
    logic          write_q, write_d;

    logic          accept;
    logic          addr_err;
    logic [3:0]    mem_we;
    logic [31:0]   mem_rdata;
    logic          unused_sideband;

    assign unused_sideband = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK};

    // HREADY is low only while some slave stretches a data phase; the
    // address phase is sampled only when it is high.
    assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

    // Any address at or beyond the array end is rejected even though the
    // index bits alone would alias back into the array.
    assign addr_err = (ahb.HSIZE > HSIZE_WORD)
                   || ((ahb.HSIZE == HSIZE_HALF) && ahb.HADDR[0])
                   || ((ahb.HSIZE == HSIZE_WORD) && (ahb.HADDR[1:0] != 2'b00))
                   || (ahb.HADDR >= 32'(4 * MEM_DEPTH_WORDS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        unique case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    idx_d   = ahb.HADDR[AW+1:2];
                    off_d   = ahb.HADDR[1:0];
                    size_d  = ahb.HSIZE;
                    write_d = ahb.HWRITE;
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Only OKAY transfers reach S_DATA, so errored writes never commit.
    // Reset on the completing edge drops the write.
    assign mem_we = (state_q == S_DATA && write_q && !reset) ? byte_en(size_q, off_q) : 4'b0000;

    ahb_sram_array #(
        .DEPTH (MEM_DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (idx_q),
        .wdata (ahb.HWDATA),
        .rdata (mem_rdata)
    );

    always_comb begin
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = HRESP_OKAY;
        ahb.HRDATA    = 32'h0;
        unique case (state_q)
            S_WAIT: ahb.HREADYOUT = 1'b0;
            S_DATA: ahb.HRDATA    = write_q ? 32'h0 : mem_rdata;
            S_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = HRESP_ERROR;
            end
            S_ERR2: ahb.HRESP     = HRESP_ERROR;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: two slaves (0 and 3 wait states) on separate buses,
// driven by directed sequences and random transfers, checked against a
// byte-addressed memory model.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        dsel;
    logic        hsel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();

    assign bus0.HSEL = hsel & ~dsel;
    assign bus1.HSEL = hsel & dsel;
    assign bus0.HADDR = haddr;         assign bus1.HADDR = haddr;
    assign bus0.HTRANS = htrans;       assign bus1.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;       assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;         assign bus1.HSIZE = hsize;
    assign bus0.HBURST = 3'b000;       assign bus1.HBURST = 3'b000;
    assign bus0.HPROT = 4'b0011;       assign bus1.HPROT = 4'b0011;
    assign bus0.HMASTLOCK = 1'b0;      assign bus1.HMASTLOCK = 1'b0;
    assign bus0.HWDATA = hwdata;       assign bus1.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;

    ahb_sram_slave #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst0), .ahb(bus0.slave));
    ahb_sram_slave #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(rst1), .ahb(bus1.slave));

    logic        ready, resp;
    logic [31:0] rdata;
    assign ready = dsel ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign resp  = dsel ? bus1.HRESP     : bus0.HRESP;
    assign rdata = dsel ? bus1.HRDATA    : bus0.HRDATA;

    int n_vec = 0;
    int n_err = 0;

    // Byte-addressed image of the low 64 bytes of each slave.
    logic [7:0] mb [2][64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_word(input int d, input logic [31:0] a);
        int w;
        w = int'(a[5:2]) * 4;
        return {mb[d][w+3], mb[d][w+2], mb[d][w+1], mb[d][w]};
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if ((a & ((32'd1 << s) - 32'd1)) != 32'd0) return 1'b1;
        return a >= 32'(4 * DEPTH);
    endfunction

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_BYTE;
        haddr  = 32'h0;
    endtask

    // One isolated transfer: address phase, then data phase until ready.
    task automatic xfer(input logic d, input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                        output logic [31:0] rd);
        bit   acc, err;
        int   exp_low, low;
        logic resp_first;
        logic [31:0] exp_rd;
        acc     = sel && tr[1];
        err     = acc && is_err(a, s);
        exp_low = !acc ? 0 : (err ? 1 : (d ? 3 : 0));
        exp_rd  = (acc && !err && !wr) ? mdl_word(int'(d), a) : 32'h0;
        dsel = d; hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = s;
        @(posedge clk); #1;
        idle_bus();
        hwdata = wd;
        low = 0;
        @(negedge clk);
        resp_first = resp;
        while (!ready && low < 20) begin
            low++;
            @(negedge clk);
        end
        chk("wait_cycles", 32'(low), 32'(exp_low));
        chk("resp_first", 32'(resp_first), 32'(err));
        chk("resp_final", 32'(resp), 32'(err));
        chk("rdata", rdata, exp_rd);
        rd = rdata;
        @(posedge clk); #1;
        if (acc && !err && wr) begin
            for (int i = 0; i < (1 << s); i++) begin
                int ai;
                ai = int'(a) + i;
                mb[int'(d)][ai] = wd[8*(ai % 4) +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        d, sel, wr;
        logic [1:0]  tr;
        logic [2:0]  s;
        logic [31:0] a;
        int          r;

        idle_bus();
        dsel = 1'b0;
        hwdata = 32'h0;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("rst0_ready", 32'(ready), 32'd1);
        chk("rst0_resp",  32'(resp),  32'd0);
        chk("rst0_rdata", rdata,      32'h0);
        dsel = 1'b1; #1;
        chk("rst1_ready", 32'(ready), 32'd1);
        chk("rst1_resp",  32'(resp),  32'd0);
        chk("rst1_rdata", rdata,      32'h0);
        @(posedge clk); #1;

        // Give both arrays known contents in the modelled region.
        for (int di = 0; di < 2; di++)
            for (int w = 0; w < 16; w++)
                xfer(1'(di), 1'b1, HTRANS_NONSEQ, 1'b1, 32'(w * 4), HSIZE_WORD, $urandom, rd);

        // Back-to-back write then read of the same word, no wait states.
        dsel = 1'b0; hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
        haddr = 32'h10; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_wr_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("b2b_rd_ready", 32'(ready), 32'd1);
        chk("b2b_rd_data",  rdata,      32'hDEADBEEF);
        @(posedge clk); #1;
        {mb[0][19], mb[0][18], mb[0][17], mb[0][16]} = 32'hDEADBEEF;

        // Byte then half write merged into a word.
        xfer(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, rd);
        xfer(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000, rd);
        xfer(1'b0, 1'b1, HTRANS_SEQ,    1'b1, 32'h10, HSIZE_HALF, 32'h00005566, rd);
        xfer(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd);
        chk("merge_word", rd, 32'hAA225566);

        // Three wait states, then reset during the second wait cycle.
        xfer(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h8, HSIZE_WORD, 32'h0, rd);
        dsel = 1'b1; hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
        haddr = 32'h4; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("ws_wait1_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(negedge clk);
        chk("ws_wait2_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(negedge clk);
        chk("ws_rst_ready", 32'(ready), 32'd1);
        chk("ws_rst_resp",  32'(resp),  32'd0);
        chk("ws_rst_rdata", rdata,      32'h0);
        @(posedge clk); #1;

        // Misaligned word write, out-of-range access, BUSY and deselected.
        xfer(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h2, HSIZE_WORD, 32'hFFFFFFFF, rd);
        xfer(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, rd);
        xfer(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'(4 * DEPTH), HSIZE_WORD, 32'h12345678, rd);
        xfer(1'b0, 1'b1, HTRANS_BUSY,   1'b1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, rd);
        xfer(1'b0, 1'b0, HTRANS_NONSEQ, 1'b1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, rd);
        xfer(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, rd);
        xfer(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, rd);

        // Random mix of sizes, alignments, types and both slaves.
        for (int k = 0; k < 160; k++) begin
            d   = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 15));
            sel = (r != 0);
            tr  = (r == 1) ? HTRANS_BUSY : (r == 2) ? HTRANS_IDLE :
                  (r % 2 == 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
            s   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a   = 32'($urandom_range(0, 63));
            if (s <= 3'd2 && $urandom_range(0, 3) != 0)
                a = a & ~((32'd1 << s) - 32'd1);
            if ($urandom_range(0, 15) == 0)
                a = a + 32'(4 * DEPTH);
            wr  = 1'($urandom_range(0, 1));
            xfer(d, sel, tr, wr, a, s, $urandom, rd);
        end

        // Final readback of every modelled word.
        for (int di = 0; di < 2; di++)
            for (int w = 0; w < 16; w++)
                xfer(1'(di), 1'b1, HTRANS_NONSEQ, 1'b0, 32'(w * 4), HSIZE_WORD, 32'h0, rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
